// File: rtl/dp_ram_be_init_if.sv
// Bus bundle for the dual-port byte-enable RAM: two access ports plus the
// shared status outputs (READY, COLL). The RAM is the slave side.
interface dp_ram_be_init_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 12,
  parameter int BYTE_W   = 8
) ();
  localparam int NBE = WIDTH / BYTE_W;

  logic                EN1;
  logic [NBE-1:0]      BE1;
  logic [ADDRBITS-1:0] ADDR1;
  logic [WIDTH-1:0]    DIN1;
  logic [WIDTH-1:0]    DOUT1;
  logic                RVALID1;

  logic                EN2;
  logic [NBE-1:0]      BE2;
  logic [ADDRBITS-1:0] ADDR2;
  logic [WIDTH-1:0]    DIN2;
  logic [WIDTH-1:0]    DOUT2;
  logic                RVALID2;

  logic                READY;
  logic                COLL;

  modport slave (
    input  EN1, BE1, ADDR1, DIN1,
    input  EN2, BE2, ADDR2, DIN2,
    output DOUT1, RVALID1, DOUT2, RVALID2, READY, COLL
  );

  modport master (
    output EN1, BE1, ADDR1, DIN1,
    output EN2, BE2, ADDR2, DIN2,
    input  DOUT1, RVALID1, DOUT2, RVALID2, READY, COLL
  );
endinterface

// File: rtl/dp_ram_be_init.sv
// True dual-port synchronous RAM with per-byte write enables, a hardware
// clear sequencer after reset, selectable read-during-write behaviour, an
// optional output register and a same-address collision flag.
// Port 1 has priority on byte lanes that both ports write in the same cycle.
module dp_ram_be_init #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4096,
  parameter int              ADDRBITS = 12,
  parameter int              BYTE_W   = 8,
  parameter int              OUT_REG  = 0,
  parameter int              RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  dp_ram_be_init_if.slave   bus
);

  localparam int NBE   = WIDTH / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             coll_q, coll_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Port signals gathered into two-entry arrays so both ports share one description
  logic                en       [2];
  logic [NBE-1:0]      be       [2];
  logic [ADDRBITS-1:0] addr     [2];
  logic [WIDTH-1:0]    din      [2];
  logic [IDX_W-1:0]    idx      [2];
  logic                in_range [2];
  logic                acc      [2];
  logic                wr       [2];
  logic [WIDTH-1:0]    old_word [2];
  logic [WIDTH-1:0]    new_word [2];
  logic [WIDTH-1:0]    rd_word  [2];

  logic [WIDTH-1:0] s1_data_q  [2];
  logic [WIDTH-1:0] s1_data_d  [2];
  logic             s1_valid_q [2];
  logic             s1_valid_d [2];
  logic [WIDTH-1:0] s2_data_q  [2];
  logic [WIDTH-1:0] s2_data_d  [2];
  logic             s2_valid_q [2];
  logic             s2_valid_d [2];

  logic run;

  assign en[0]   = bus.EN1;
  assign be[0]   = bus.BE1;
  assign addr[0] = bus.ADDR1;
  assign din[0]  = bus.DIN1;
  assign en[1]   = bus.EN2;
  assign be[1]   = bus.BE2;
  assign addr[1] = bus.ADDR2;
  assign din[1]  = bus.DIN2;

  assign run = (state_q == ST_RUN);

  // Clear sequencer: walk every word once after reset, then serve the ports
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  // State and counter register; reset restarts the clear from word 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-port decode: range check, old word, byte-merged word and the read result
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]      = IDX_W'(addr[p]);
      in_range[p] = (32'(addr[p]) < DEPTH);
      acc[p]      = run && en[p];
      wr[p]       = acc[p] && in_range[p] && (|be[p]);
      old_word[p] = '0;
      if (in_range[p]) begin
        old_word[p] = mem_q[idx[p]];
      end
      new_word[p] = old_word[p];
      for (int k = 0; k < NBE; k++) begin
        if (be[p][k] && in_range[p]) begin
          new_word[p][k*BYTE_W +: BYTE_W] = din[p][k*BYTE_W +: BYTE_W];
        end
      end
      rd_word[p] = (RDW_MODE != 0) ? new_word[p] : old_word[p];
    end
  end

  // Storage array: clear writes during CLEAR, byte-lane writes in RUN with port 1 applied last
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= INIT_VAL;
      end else begin
        for (int k = 0; k < NBE; k++) begin
          if (wr[1] && be[1][k]) begin
            mem_q[idx[1]][k*BYTE_W +: BYTE_W] <= din[1][k*BYTE_W +: BYTE_W];
          end
          if (wr[0] && be[0][k]) begin
            mem_q[idx[0]][k*BYTE_W +: BYTE_W] <= din[0][k*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Read pipeline: stage 1 captures each access, stage 2 re-times it when the output register is used
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s1_data_d[p]  = acc[p] ? rd_word[p] : s1_data_q[p];
      s1_valid_d[p] = acc[p];
      s2_data_d[p]  = s1_valid_q[p] ? s1_data_q[p] : s2_data_q[p];
      s2_valid_d[p] = s1_valid_q[p];
    end
    coll_d = acc[0] && acc[1] && (addr[0] == addr[1]) && ((|be[0]) || (|be[1]));
  end

  // Pipeline and collision flag registers, all zeroed by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int p = 0; p < 2; p++) begin
        s1_data_q[p]  <= '0;
        s1_valid_q[p] <= 1'b0;
        s2_data_q[p]  <= '0;
        s2_valid_q[p] <= 1'b0;
      end
      coll_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_data_q[p]  <= s1_data_d[p];
        s1_valid_q[p] <= s1_valid_d[p];
        s2_data_q[p]  <= s2_data_d[p];
        s2_valid_q[p] <= s2_valid_d[p];
      end
      coll_q <= coll_d;
    end
  end

  assign bus.DOUT1   = (OUT_REG != 0) ? s2_data_q[0]  : s1_data_q[0];
  assign bus.RVALID1 = (OUT_REG != 0) ? s2_valid_q[0] : s1_valid_q[0];
  assign bus.DOUT2   = (OUT_REG != 0) ? s2_data_q[1]  : s1_data_q[1];
  assign bus.RVALID2 = (OUT_REG != 0) ? s2_valid_q[1] : s1_valid_q[1];
  assign bus.READY   = run;
  assign bus.COLL    = coll_q;

endmodule
